pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch, call/return and a circular RAS.
// Redirects land on pc one cycle after the requesting edge.
module pc_sequencer #(
  parameter int                WIDTH     = 32,
  parameter int                STEP      = 1,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             fetch_valid,
  output logic             ras_empty,
  output logic             ras_full,
  output logic [1:0]       ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_top;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] pc_d;
  logic [PW-1:0]    sp_d;
  logic [CW-1:0]    cnt_d;
  logic [1:0]       err_d;
  logic             fv_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             advance;
  logic             do_cr;
  logic             do_call;
  logic             do_ret;
  logic             do_br;

  assign pc_next_seq = pc + STEP_W;
  assign sp_top      = sp - PW'(1);
  assign ras_empty   = (cnt == '0);
  assign ras_full    = (cnt == DEPTH_C);

  assign advance = fetch_valid & ~stall;
  assign do_cr   = call_en & ret_en;
  assign do_call = call_en & ~ret_en;
  assign do_ret  = ret_en & ~call_en;
  assign do_br   = branch_en & ~call_en & ~ret_en;

  // Next pc, stack pointer, count and error flags by request priority
  always_comb begin
    pc_d   = pc;
    sp_d   = sp;
    cnt_d  = cnt;
    err_d  = ras_err;
    fv_d   = fetch_valid | ~stall;
    wr_en  = 1'b0;
    wr_idx = sp;
    if (advance) begin
      unique case (1'b1)
        do_cr: begin
          pc_d  = branch_target;
          wr_en = 1'b1;
          if (ras_empty) begin
            sp_d  = sp + PW'(1);
            cnt_d = cnt + CW'(1);
          end else begin
            wr_idx = sp_top;
          end
        end
        do_call: begin
          pc_d  = branch_target;
          wr_en = 1'b1;
          sp_d  = sp + PW'(1);
          if (ras_full) err_d[0] = 1'b1;
          else          cnt_d    = cnt + CW'(1);
        end
        do_ret: begin
          if (ras_empty) begin
            pc_d     = pc_next_seq;
            err_d[1] = 1'b1;
          end else begin
            pc_d  = stack[sp_top];
            sp_d  = sp_top;
            cnt_d = cnt - CW'(1);
          end
        end
        do_br:   pc_d = branch_target;
        default: pc_d = pc_next_seq;
      endcase
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VEC;
      sp          <= '0;
      cnt         <= '0;
      ras_err     <= '0;
      fetch_valid <= 1'b0;
    end else begin
      pc          <= pc_d;
      sp          <= sp_d;
      cnt         <= cnt_d;
      ras_err     <= err_d;
      fetch_valid <= fv_d;
    end
  end

  // Stack storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= pc_next_seq;
  end

endmodule
